spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  SPI receive endpoint. Pairs with the counter-pattern SPI master (byte counter, LSB-first on mosi).
//  Oversamples sclk/cs_n/mosi on clk_spi, deserialises DATA_W-bit words and pulses rx_valid per word.
//  Checks that words form an incrementing sequence (mod 2^DATA_W) and counts violations.
//  Sits on the bench/FPGA top as the link checker for the master's output.
// PARAMETERS
//  DATA_W       8   bits per word
//  LSB_FIRST    1   1: first received bit -> rx_data[0]; 0: first bit -> rx_data[DATA_W-1]
//  SYNC_STAGES  2   synchroniser depth on sclk, cs_n, mosi (>=2)
//  USE_CS       1   0: cs_n ignored, link treated as always selected
//  ERR_W        16  width of err_count
// PORTS
//  clk_spi    in   1       oversampling clock, all logic on posedge
//  reset      in   1       asynchronous, active-low
//  sclk       in   1       serial bit clock from master, async to clk_spi; data sampled on rising edge
//  cs_n       in   1       chip select, active-low, async
//  mosi       in   1       serial data, async
//  rx_data    out  DATA_W  last completed word, held until next word
//  rx_valid   out  1       1-cycle pulse, rx_data new
//  seq_err    out  1       1-cycle pulse coincident with rx_valid when word != expected
//  frame_err  out  1       1-cycle pulse when cs_n deasserts with 1..DATA_W-1 bits shifted
//  locked     out  1       1 once the first word after reset/cs release is seen
//  err_count  out  ERR_W   seq_err + frame_err events since reset, saturating at all-ones
// BEHAVIOUR
//  Reset (async assert, sync release by flops): all outputs 0, sync chains 0, bit_cnt 0, FSM IDLE, expected 0.
//  Sync: sclk/cs_n/mosi each through SYNC_STAGES flops; sclk_rise = sync_sclk & ~sclk_d (one extra flop);
//   mosi sampled from the same pipeline depth as sclk so bit/edge stay aligned.
//  sel = USE_CS ? ~sync_cs_n : 1.
//  FSM IDLE: bit_cnt=0. sel=1 -> SHIFT (edge in the same cycle is taken as bit 0).
//  FSM SHIFT: on sclk_rise shift bit into shreg per LSB_FIRST, bit_cnt++.
//   bit_cnt reaches DATA_W: next cycle rx_data<=shreg, rx_valid=1, bit_cnt<=0, stay SHIFT (back-to-back words, no gap needed).
//   sel=0: -> IDLE; if bit_cnt in 1..DATA_W-1 pulse frame_err, partial word discarded, locked<=0.
//   sel falling and sclk_rise in same cycle: edge ignored.
//  Latency: rx_valid 1 clk_spi after the cycle sclk_rise of the last bit is detected
//   (SYNC_STAGES+2 clk_spi after the raw sclk edge).
//  Sequence check (on rx_valid word w): locked=0 -> expected<=w+1, locked<=1, no error.
//   locked=1: w!=expected -> seq_err pulse; in all cases expected<=w+1 (resync to stream).
//   Wrap: expected 0xFF+1 = 0x00 (mod 2^DATA_W), 0xFF->0x00 is not an error.
//  err_count += 1 per seq_err or frame_err cycle (never both in one cycle); holds at 2^ERR_W-1.
//  Constraint: sclk high and low phases each >= SYNC_STAGES+1 clk_spi periods; faster sclk undefined.
//  Reset mid-word: partial word lost, no frame_err, locked=0.
// STRUCTURE
//  Package spi_pkg: DATA_W default, FSM state enum {IDLE, SHIFT}, localparam of the sequence step (1).
//  Sub-module spi_in_sync: N-stage synchroniser + rising-edge detect, instantiated for sclk, cs_n and mosi
//   (mosi edge output unused).
//  Top: deserialiser FSM + bit counter, sequence checker, saturating error counter.
// TESTING
//  1 Master-style stream 0x00,0x01..0xFF,0x00, sclk = clk_spi/17, USE_CS=0 -> 257 rx_valid,
//    rx_data matches, seq_err never, err_count=0, locked=1 after first word.
//  2 Bytes 0x10,0x11,0x13,0x14 -> one seq_err on 0x13, no error on 0x14, err_count=1.
//  3 cs_n high after 5 bits, then full byte 0xA5 -> frame_err once, locked=0, next rx_data=0xA5, no seq_err.
//  4 LSB_FIRST=0 sending 0x01 MSB-first -> rx_data=0x01; LSB_FIRST=1 same wire bits -> 0x80.
//  5 reset low after 3 bits of 0x3C, release, send 0x3C -> no rx_valid before release, rx_data=0x3C, err_count=0.
//  6 ERR_W=2, 5 mismatching bytes -> err_count saturates at 3.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive link checker.
package spi_pkg;

  localparam int DATA_W_DEF = 8;

  // Amount the sequence checker expects each word to advance by.
  localparam int SEQ_STEP = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Serial input pins plus the receive/status outputs of the link checker.
interface spi_slave_rx_if #(
  parameter int DATA_W = 8,
  parameter int ERR_W  = 16
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              seq_err;
  logic              frame_err;
  logic              locked;
  logic [ERR_W-1:0]  err_count;

  modport master (
    output sclk, cs_n, mosi,
    input  rx_data, rx_valid, seq_err, frame_err, locked, err_count
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output rx_data, rx_valid, seq_err, frame_err, locked, err_count
  );
endinterface

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one asynchronous input, with rising-edge detect
// taken one flop after the synchronised output.
module spi_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_spi,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);
  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  // Shift the raw input through the chain and keep one delayed copy for edges.
  always_ff @(posedge clk_spi or negedge reset) begin
    if (!reset) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign q_o    = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive endpoint and link checker: deserialises words from an
// oversampled sclk/mosi pair and verifies they form an incrementing sequence.
//
//   state | meaning
//   IDLE  | not selected, bit counter held at 0
//   SHIFT | selected, shifting bits on each sclk rising edge
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2,
  parameter bit USE_CS      = 1'b1,
  parameter int ERR_W       = 16
) (
  input logic           clk_spi,
  input logic           reset,
  spi_slave_rx_if.slave bus
);
  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  logic sclk_s, sclk_rise, cs_n_s, mosi_s;
  logic cs_rise_unused, mosi_rise_unused;
  logic sel;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, shifted;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] expected_q, expected_d;
  logic              rx_valid_q, seq_err_q, seq_err_d, frame_err_q, frame_err_d;
  logic              locked_q, locked_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic              word_done;

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_spi(clk_spi), .reset(reset), .d_i(bus.sclk), .q_o(sclk_s), .rise_o(sclk_rise)
  );
  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_spi(clk_spi), .reset(reset), .d_i(bus.cs_n), .q_o(cs_n_s), .rise_o(cs_rise_unused)
  );
  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk_spi(clk_spi), .reset(reset), .d_i(bus.mosi), .q_o(mosi_s), .rise_o(mosi_rise_unused)
  );

  assign sel     = USE_CS ? ~cs_n_s : 1'b1;
  assign shifted = LSB_FIRST ? {mosi_s, shreg_q[DATA_W-1:1]} : {shreg_q[DATA_W-2:0], mosi_s};

  // Deserialiser: next state, bit counter, shift register, word/frame events.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    word_done   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (sel) begin
          state_d = SHIFT;
          if (sclk_rise) begin
            shreg_d   = shifted;
            bit_cnt_d = CNT_W'(1);
          end
        end
      end
      SHIFT: begin
        // A completed word is still delivered even if select drops now.
        if (bit_cnt_q == CNT_FULL) begin
          word_done = 1'b1;
          bit_cnt_d = '0;
        end
        if (!sel) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          if (bit_cnt_q != '0 && bit_cnt_q != CNT_FULL) frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          shreg_d   = shifted;
          bit_cnt_d = (word_done ? CNT_W'(0) : bit_cnt_q) + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequence checker and saturating error counter.
  always_comb begin
    rx_data_d   = word_done ? shreg_q : rx_data_q;
    seq_err_d   = word_done && locked_q && (shreg_q != expected_q);
    expected_d  = word_done ? shreg_q + DATA_W'(SEQ_STEP) : expected_q;
    locked_d    = locked_q;
    if (frame_err_d)    locked_d = 1'b0;
    else if (word_done) locked_d = 1'b1;
    err_count_d = err_count_q;
    if ((seq_err_d || frame_err_d) && err_count_q != ERR_MAX)
      err_count_d = err_count_q + ERR_W'(1);
  end

  // State and output registers.
  always_ff @(posedge clk_spi or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      locked_q    <= 1'b0;
      expected_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= word_done;
      seq_err_q   <= seq_err_d;
      frame_err_q <= frame_err_d;
      locked_q    <= locked_d;
      expected_q  <= expected_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.frame_err = frame_err_q;
  assign bus.locked    = locked_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: four parameterisations share one serial stimulus.
// Index 0: default, 1: MSB-first, 2: ERR_W=2, 3: USE_CS=0.
module tb_spi_slave_rx;
  logic clk_spi = 1'b0;
  logic reset   = 1'b0;
  logic sclk    = 1'b0;
  logic cs_n    = 1'b1;
  logic mosi    = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int         vcnt[4];
  int         scnt[4];
  int         fcnt[4];
  int         seq_alone;
  logic [7:0] last[4];

  always #5 clk_spi = ~clk_spi;

  spi_slave_rx_if #(.DATA_W(8), .ERR_W(16)) if_lsb ();
  spi_slave_rx_if #(.DATA_W(8), .ERR_W(16)) if_msb ();
  spi_slave_rx_if #(.DATA_W(8), .ERR_W(2))  if_e2 ();
  spi_slave_rx_if #(.DATA_W(8), .ERR_W(16)) if_nocs ();

  assign if_lsb.sclk  = sclk;  assign if_lsb.cs_n  = cs_n;  assign if_lsb.mosi  = mosi;
  assign if_msb.sclk  = sclk;  assign if_msb.cs_n  = cs_n;  assign if_msb.mosi  = mosi;
  assign if_e2.sclk   = sclk;  assign if_e2.cs_n   = cs_n;  assign if_e2.mosi   = mosi;
  assign if_nocs.sclk = sclk;  assign if_nocs.cs_n = cs_n;  assign if_nocs.mosi = mosi;

  spi_slave_rx #(.DATA_W(8), .LSB_FIRST(1'b1), .SYNC_STAGES(2), .USE_CS(1'b1), .ERR_W(16))
    dut_lsb (.clk_spi(clk_spi), .reset(reset), .bus(if_lsb.slave));
  spi_slave_rx #(.DATA_W(8), .LSB_FIRST(1'b0), .SYNC_STAGES(2), .USE_CS(1'b1), .ERR_W(16))
    dut_msb (.clk_spi(clk_spi), .reset(reset), .bus(if_msb.slave));
  spi_slave_rx #(.DATA_W(8), .LSB_FIRST(1'b1), .SYNC_STAGES(2), .USE_CS(1'b1), .ERR_W(2))
    dut_e2 (.clk_spi(clk_spi), .reset(reset), .bus(if_e2.slave));
  spi_slave_rx #(.DATA_W(8), .LSB_FIRST(1'b1), .SYNC_STAGES(2), .USE_CS(1'b0), .ERR_W(16))
    dut_nocs (.clk_spi(clk_spi), .reset(reset), .bus(if_nocs.slave));

  initial begin
    for (int i = 0; i < 4; i++) begin
      vcnt[i] = 0; scnt[i] = 0; fcnt[i] = 0; last[i] = '0;
    end
    seq_alone = 0;
  end

  // Event monitors, sampled on the falling clock edge.
  always @(negedge clk_spi) begin
    if (if_lsb.rx_valid)  begin vcnt[0]++; last[0] = if_lsb.rx_data;  end
    if (if_msb.rx_valid)  begin vcnt[1]++; last[1] = if_msb.rx_data;  end
    if (if_e2.rx_valid)   begin vcnt[2]++; last[2] = if_e2.rx_data;   end
    if (if_nocs.rx_valid) begin vcnt[3]++; last[3] = if_nocs.rx_data; end
    if (if_lsb.seq_err)  scnt[0]++;
    if (if_e2.seq_err)   scnt[2]++;
    if (if_nocs.seq_err) scnt[3]++;
    if (if_lsb.seq_err && !if_lsb.rx_valid) seq_alone++;
    if (if_lsb.frame_err)  fcnt[0]++;
    if (if_nocs.frame_err) fcnt[3]++;
  end

  task automatic send_bit(input logic b);
    sclk = 1'b0;
    mosi = b;
    repeat (8) @(negedge clk_spi);
    sclk = 1'b1;
    repeat (9) @(negedge clk_spi);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit lsb_first);
    for (int i = 0; i < 8; i++) send_bit(lsb_first ? v[i] : v[7-i]);
  endtask

  task automatic do_reset();
    @(negedge clk_spi);
    reset = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    repeat (3) @(negedge clk_spi);
    reset = 1'b1;
    repeat (3) @(negedge clk_spi);
  endtask

  task automatic test_reset();
    @(negedge clk_spi);
    reset = 1'b0;
    repeat (2) @(negedge clk_spi);
    total_cnt++;
    if (if_lsb.rx_valid !== 1'b0 || if_lsb.locked !== 1'b0 || if_lsb.seq_err !== 1'b0 || if_lsb.frame_err !== 1'b0)
      $display("FAIL reset_flags valid=%b locked=%b seq=%b frame=%b required all 0",
               if_lsb.rx_valid, if_lsb.locked, if_lsb.seq_err, if_lsb.frame_err);
    else pass_cnt++;
    total_cnt++;
    if (if_lsb.rx_data !== 8'h00) $display("FAIL reset_rx_data got %h required 00", if_lsb.rx_data);
    else pass_cnt++;
    total_cnt++;
    if (if_lsb.err_count !== 16'd0) $display("FAIL reset_err_count got %0d required 0", if_lsb.err_count);
    else pass_cnt++;
    total_cnt++;
    if (if_e2.err_count !== 2'd0) $display("FAIL reset_err_count_e2 got %0d required 0", if_e2.err_count);
    else pass_cnt++;
    reset = 1'b1;
    repeat (3) @(negedge clk_spi);
  endtask

  task automatic test_stream();
    int base;
    logic [7:0] b;
    do_reset();
    cs_n = 1'b0;
    repeat (4) @(negedge clk_spi);
    base = vcnt[3];
    for (int i = 0; i < 257; i++) begin
      b = 8'(i);
      send_byte(b, 1'b1);
      total_cnt++;
      if (vcnt[3] - base !== i + 1 || last[3] !== b)
        $display("FAIL stream_word idx=%0d got cnt=%0d data=%h required cnt=%0d data=%h",
                 i, vcnt[3] - base, last[3], i + 1, b);
      else pass_cnt++;
      if (i == 0) begin
        total_cnt++;
        if (if_nocs.locked !== 1'b1) $display("FAIL stream_locked got %b required 1", if_nocs.locked);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (scnt[3] !== 0) $display("FAIL stream_seq_err got %0d required 0", scnt[3]);
    else pass_cnt++;
    total_cnt++;
    if (if_nocs.err_count !== 16'd0) $display("FAIL stream_err_count got %0d required 0", if_nocs.err_count);
    else pass_cnt++;
    total_cnt++;
    if (if_lsb.err_count !== 16'd0 || last[0] !== 8'h00)
      $display("FAIL stream_cs_dut got err=%0d data=%h required err=0 data=00", if_lsb.err_count, last[0]);
    else pass_cnt++;
    cs_n = 1'b1;
  endtask

  task automatic test_seq_err();
    int s0;
    do_reset();
    cs_n = 1'b0;
    repeat (4) @(negedge clk_spi);
    s0 = scnt[0];
    send_byte(8'h10, 1'b1);
    send_byte(8'h11, 1'b1);
    total_cnt++;
    if (scnt[0] - s0 !== 0) $display("FAIL seq_in_order got %0d errors required 0", scnt[0] - s0);
    else pass_cnt++;
    send_byte(8'h13, 1'b1);
    total_cnt++;
    if (scnt[0] - s0 !== 1 || last[0] !== 8'h13)
      $display("FAIL seq_gap got errors=%0d data=%h required errors=1 data=13", scnt[0] - s0, last[0]);
    else pass_cnt++;
    send_byte(8'h14, 1'b1);
    total_cnt++;
    if (scnt[0] - s0 !== 1) $display("FAIL seq_resync got %0d errors required 1", scnt[0] - s0);
    else pass_cnt++;
    total_cnt++;
    if (if_lsb.err_count !== 16'd1) $display("FAIL seq_err_count got %0d required 1", if_lsb.err_count);
    else pass_cnt++;
    total_cnt++;
    if (seq_alone !== 0) $display("FAIL seq_coincident got %0d lone pulses required 0", seq_alone);
    else pass_cnt++;
    cs_n = 1'b1;
  endtask

  task automatic test_frame_err();
    int f0, s0;
    do_reset();
    cs_n = 1'b0;
    repeat (4) @(negedge clk_spi);
    send_byte(8'h20, 1'b1);
    f0 = fcnt[0];
    s0 = scnt[0];
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    cs_n = 1'b1;
    repeat (10) @(negedge clk_spi);
    total_cnt++;
    if (fcnt[0] - f0 !== 1) $display("FAIL frame_pulse got %0d required 1", fcnt[0] - f0);
    else pass_cnt++;
    total_cnt++;
    if (if_lsb.locked !== 1'b0) $display("FAIL frame_unlock got %b required 0", if_lsb.locked);
    else pass_cnt++;
    total_cnt++;
    if (if_lsb.err_count !== 16'd1) $display("FAIL frame_err_count got %0d required 1", if_lsb.err_count);
    else pass_cnt++;
    sclk = 1'b0;
    cs_n = 1'b0;
    repeat (4) @(negedge clk_spi);
    send_byte(8'hA5, 1'b1);
    cs_n = 1'b1;
    repeat (10) @(negedge clk_spi);
    total_cnt++;
    if (last[0] !== 8'hA5 || scnt[0] - s0 !== 0)
      $display("FAIL frame_recover got data=%h seq=%0d required data=a5 seq=0", last[0], scnt[0] - s0);
    else pass_cnt++;
    total_cnt++;
    if (if_lsb.locked !== 1'b1 || fcnt[0] - f0 !== 1)
      $display("FAIL frame_relock got locked=%b frames=%0d required locked=1 frames=1", if_lsb.locked, fcnt[0] - f0);
    else pass_cnt++;
  endtask

  task automatic test_bit_order();
    do_reset();
    cs_n = 1'b0;
    repeat (4) @(negedge clk_spi);
    send_byte(8'h01, 1'b0);
    total_cnt++;
    if (last[1] !== 8'h01) $display("FAIL order_msb got %h required 01", last[1]);
    else pass_cnt++;
    total_cnt++;
    if (last[0] !== 8'h80) $display("FAIL order_lsb got %h required 80", last[0]);
    else pass_cnt++;
    cs_n = 1'b1;
  endtask

  task automatic test_latency();
    int n;
    logic [7:0] v;
    v = 8'h5A;
    do_reset();
    cs_n = 1'b0;
    repeat (4) @(negedge clk_spi);
    for (int i = 0; i < 7; i++) send_bit(v[i]);
    sclk = 1'b0;
    mosi = v[7];
    repeat (8) @(negedge clk_spi);
    sclk = 1'b1;
    n = 0;
    while (!if_lsb.rx_valid && n < 20) begin
      @(negedge clk_spi);
      n++;
    end
    total_cnt++;
    if (n !== 4) $display("FAIL latency got %0d cycles required 4", n);
    else pass_cnt++;
    total_cnt++;
    if (if_lsb.rx_data !== 8'h5A) $display("FAIL latency_data got %h required 5a", if_lsb.rx_data);
    else pass_cnt++;
    repeat (8) @(negedge clk_spi);
    cs_n = 1'b1;
  endtask

  task automatic test_reset_mid_word();
    int v0, f0;
    do_reset();
    cs_n = 1'b0;
    repeat (4) @(negedge clk_spi);
    v0 = vcnt[0];
    f0 = fcnt[0];
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b0;
    @(negedge clk_spi);
    sclk = 1'b0;
    repeat (5) @(negedge clk_spi);
    total_cnt++;
    if (vcnt[0] - v0 !== 0 || fcnt[0] - f0 !== 0 || if_lsb.locked !== 1'b0)
      $display("FAIL midreset_quiet got valid=%0d frame=%0d locked=%b required 0 0 0",
               vcnt[0] - v0, fcnt[0] - f0, if_lsb.locked);
    else pass_cnt++;
    reset = 1'b1;
    repeat (4) @(negedge clk_spi);
    send_byte(8'h3C, 1'b1);
    total_cnt++;
    if (last[0] !== 8'h3C || vcnt[0] - v0 !== 1)
      $display("FAIL midreset_word got data=%h cnt=%0d required data=3c cnt=1", last[0], vcnt[0] - v0);
    else pass_cnt++;
    total_cnt++;
    if (if_lsb.err_count !== 16'd0) $display("FAIL midreset_err_count got %0d required 0", if_lsb.err_count);
    else pass_cnt++;
    cs_n = 1'b1;
  endtask

  task automatic test_saturate();
    do_reset();
    cs_n = 1'b0;
    repeat (4) @(negedge clk_spi);
    send_byte(8'h50, 1'b1);
    send_byte(8'h50, 1'b1);
    send_byte(8'h50, 1'b1);
    total_cnt++;
    if (if_e2.err_count !== 2'd2) $display("FAIL sat_two got %0d required 2", if_e2.err_count);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) send_byte(8'h50, 1'b1);
    total_cnt++;
    if (if_e2.err_count !== 2'd3) $display("FAIL sat_hold got %0d required 3", if_e2.err_count);
    else pass_cnt++;
    total_cnt++;
    if (if_lsb.err_count !== 16'd5) $display("FAIL sat_wide got %0d required 5", if_lsb.err_count);
    else pass_cnt++;
    cs_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_seq_err();
    test_frame_err();
    test_bit_order();
    test_latency();
    test_reset_mid_word();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
